row_skew_feeder: RTL and testbench

//  Upstream feeder for the left edge of the PE systolic array. Accepts one
//  NUM_ROWS-wide column vector per handshake and skews it so that row r

---
 rtl/row_skew_feeder.sv | 98 +++++++++
 tb/tb_row_skew_feeder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/row_skew_feeder.sv
// Left-edge feeder for the PE systolic array: skews each accepted column vector so
// row r arrives r cycles after row 0, then drains zeros and pulses done.
module row_skew_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ROWS   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_ROWS*DATA_WIDTH-1:0] in_data,
  input  logic                           in_last,
  output logic [NUM_ROWS*DATA_WIDTH-1:0] out_data,
  output logic [NUM_ROWS-1:0]            out_valid,
  output logic                           busy,
  output logic                           done
);

  localparam int CNT_W = (NUM_ROWS > 2) ? $clog2(NUM_ROWS) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(NUM_ROWS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, FEED: begin
        if (accept) begin
          if (in_last) begin
            state_d = DRAIN;
            cnt_d   = DRAIN_LOAD;
          end else begin
            state_d = FEED;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE) || (state_q == FEED);
    busy     = (state_q != IDLE);
    done     = (state_q == DRAIN) && (cnt_q == '0);
  end

  // Lane r: delay line of depth r+1; a non-accept cycle injects a zero bubble.
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_lane
    localparam int DEPTH = r + 1;
    logic [DATA_WIDTH-1:0] data_p [DEPTH];
    logic                  vld_p  [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int s = 0; s < DEPTH; s++) begin
          data_p[s] <= '0;
          vld_p[s]  <= 1'b0;
        end
      end else begin
        data_p[0] <= accept ? in_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
        vld_p[0]  <= accept;
        for (int s = 1; s < DEPTH; s++) begin
          data_p[s] <= data_p[s-1];
          vld_p[s]  <= vld_p[s-1];
        end
      end
    end

    assign out_data[r*DATA_WIDTH +: DATA_WIDTH] = data_p[DEPTH-1];
    assign out_valid[r]                         = vld_p[DEPTH-1];
  end

endmodule

// File: tb/tb_row_skew_feeder.sv
// Bench for row_skew_feeder: directed scenarios plus random traffic against a
// timeline model (accept history per edge, last-accept edge, stream-open flag).
module tb_row_skew_feeder;
  localparam int DW   = 32;
  localparam int NR   = 4;
  localparam int BW   = NR * DW;
  localparam int MAXE = 4000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic [BW-1:0] out_data;
  logic [NR-1:0] out_valid;
  logic          busy;
  logic          done;

  row_skew_feeder #(.DATA_WIDTH(DW), .NUM_ROWS(NR)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_data(out_data),
    .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state: what was accepted at each edge, since the most recent reset.
  logic          acc_v [MAXE];
  logic [BW-1:0] acc_d [MAXE];
  int            ecount = 0;
  int            base = 0;
  int            last_edge = -1000;
  logic          stream_open = 1'b0;

  task automatic check_val(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, ecount, obs, exp);
    end
  endtask

  function automatic logic draining(input int k);
    return (last_edge >= base) && (k >= last_edge) && (k <= last_edge + NR - 1);
  endfunction

  function automatic logic done_at(input int k);
    return (last_edge >= base) && (k == last_edge + NR - 1);
  endfunction

  task automatic compare();
    int k;
    int e;
    logic [BW-1:0] exp_d;
    logic [NR-1:0] exp_v;
    k = ecount - 1;
    exp_d = '0;
    exp_v = '0;
    for (int r = 0; r < NR; r++) begin
      e = k - r;
      if (e >= base && acc_v[e]) begin
        exp_d[r*DW +: DW] = acc_d[e][r*DW +: DW];
        exp_v[r] = 1'b1;
      end
    end
    check_val("in_ready", BW'(in_ready), BW'(!draining(k)));
    check_val("busy", BW'(busy), BW'(stream_open || draining(k)));
    check_val("done", BW'(done), BW'(done_at(k)));
    check_val("out_valid", BW'(out_valid), BW'(exp_v));
    check_val("out_data", out_data, exp_d);
  endtask

  task automatic step(input logic v, input logic l, input logic [BW-1:0] d);
    logic acc;
    in_valid = v;
    in_last  = l;
    in_data  = d;
    acc = v && !draining(ecount - 1);
    acc_v[ecount] = acc;
    acc_d[ecount] = acc ? d : '0;
    if (acc) begin
      if (l) begin
        last_edge   = ecount;
        stream_open = 1'b0;
      end else begin
        stream_open = 1'b1;
      end
    end
    @(posedge clk);
    ecount++;
    #1 compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom_range(0, 1) == 1, {$urandom, $urandom, $urandom, $urandom});
  endtask

  // Async reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check_val("rst_out_data", out_data, '0);
    check_val("rst_out_valid", BW'(out_valid), '0);
    check_val("rst_busy", BW'(busy), '0);
    check_val("rst_in_ready", BW'(in_ready), BW'(1));
    check_val("rst_done", BW'(done), '0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    ecount++;
    #1 reset = 1'b0;
    base        = ecount;
    last_edge   = -1000;
    stream_open = 1'b0;
  endtask

  function automatic logic [BW-1:0] mkvec(input int k);
    logic [BW-1:0] v;
    v = '0;
    for (int r = 0; r < NR; r++) v[r*DW +: DW] = DW'(10 * k + r);
    return v;
  endfunction

  initial begin
    @(posedge clk);
    ecount++;
    #1 do_reset();

    // Single vector with last
    step(1'b1, 1'b1, {32'd4, 32'd3, 32'd2, 32'd1});
    idle(6);

    // Back-to-back three vectors
    for (int k = 0; k < 3; k++) step(1'b1, k == 2, mkvec(k));
    idle(6);

    // Bubble between two vectors
    step(1'b1, 1'b0, mkvec(5));
    step(1'b0, 1'b0, mkvec(9));
    step(1'b1, 1'b1, mkvec(6));
    idle(6);

    // Reset two cycles into DRAIN, then a clean single-vector stream
    step(1'b1, 1'b1, mkvec(7));
    idle(2);
    do_reset();
    idle(1);
    step(1'b1, 1'b1, {32'd4, 32'd3, 32'd2, 32'd1});
    idle(6);

    // in_valid held through DRAIN; the held vector goes in once back in IDLE
    step(1'b1, 1'b1, mkvec(1));
    for (int i = 0; i < NR + 1; i++) step(1'b1, 1'b0, mkvec(2));
    step(1'b1, 1'b1, mkvec(3));
    idle(6);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step($urandom_range(0, 9) < 7, $urandom_range(0, 5) == 0,
           {$urandom, $urandom, $urandom, $urandom});
    end
    step(1'b1, 1'b1, mkvec(8));
    idle(NR + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
